// File: rtl/axis_tx_min_frame_pad_pkg.sv
// Shared definitions for the TX minimum-frame padder.
//   MIN_FRAME_BYTES        : minimum frame length, FCS excluded
//   AXIS_DATA_W/AXIS_KEEP_W: stream widths the keep helpers are sized for
//   pad_state_t            : padder FSM states
//   axis_keep_popcount     : number of enabled bytes in a tkeep word
//   axis_keep_to_byte_mask : tkeep expanded to a per-bit data mask
package axis_tx_min_frame_pad_pkg;

  localparam int MIN_FRAME_BYTES = 60;
  localparam int AXIS_DATA_W     = 32;
  localparam int AXIS_KEEP_W     = AXIS_DATA_W / 8;
  localparam int POPCNT_W        = $clog2(AXIS_KEEP_W + 1);

  typedef enum logic {
    PASS = 1'b0,
    PAD  = 1'b1
  } pad_state_t;

  function automatic logic [POPCNT_W-1:0] axis_keep_popcount(
    input logic [AXIS_KEEP_W-1:0] keep
  );
    logic [POPCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < AXIS_KEEP_W; i++) begin
      n = n + POPCNT_W'(keep[i]);
    end
    return n;
  endfunction

  function automatic logic [AXIS_DATA_W-1:0] axis_keep_to_byte_mask(
    input logic [AXIS_KEEP_W-1:0] keep
  );
    logic [AXIS_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < AXIS_KEEP_W; i++) begin
      m[i*8 +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_tx_min_frame_pad_if.sv
// AXI-Stream bundle used on both sides of the padder.
//   tdata/tkeep/tvalid/tlast : driven by the master
//   trdy                     : driven by the slave
interface axis_tx_min_frame_pad_if
  import axis_tx_min_frame_pad_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_W,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  trdy;

  modport master (
    output tdata, tkeep, tvalid, tlast,
    input  trdy
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast,
    output trdy
  );

endinterface

// File: rtl/axis_tx_min_frame_pad_out_reg.sv
// Registered output stage of the padder.
//   load/load_*  : new beat to capture (only asserted when the stage is free)
//   out_rdy      : downstream ready
//   out_*        : held beat; stable while out_valid && !out_rdy
//   out_pad      : beat belongs to a frame that was padded
module axis_tx_min_frame_pad_out_reg
  import axis_tx_min_frame_pad_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_W,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [KEEP_WIDTH-1:0] load_keep,
  input  logic                  load_last,
  input  logic                  load_pad,
  input  logic                  out_rdy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [KEEP_WIDTH-1:0] out_keep,
  output logic                  out_last,
  output logic                  out_pad
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic                  last_q, last_d;
  logic                  pad_q, pad_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    pad_d   = pad_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      keep_d  = load_keep;
      last_d  = load_last;
      pad_d   = load_pad;
    end else if (out_rdy) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;
  assign out_pad   = pad_q;

endmodule

// File: rtl/axis_tx_min_frame_pad.sv
// Zero-pads TX frames shorter than MIN_FRAME_BYTES (FCS excluded).
//   clk, reset   : single clock, synchronous active-high reset
//   s_axis       : user frames in (slave modport)
//   m_axis       : frames towards the MAC framer (master modport), registered
//   frame_padded : pulses when the final beat of a padded frame is accepted
//
// state | meaning
// PASS  | forwarding user beats; input ready follows the output stage
// PAD   | emitting all-zero filler beats; input held off
module axis_tx_min_frame_pad
  import axis_tx_min_frame_pad_pkg::*;
#(
  parameter int DATA_WIDTH      = AXIS_DATA_W,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int MIN_FRAME_BYTES = axis_tx_min_frame_pad_pkg::MIN_FRAME_BYTES
) (
  input  logic                     clk,
  input  logic                     reset,
  axis_tx_min_frame_pad_if.slave   s_axis,
  axis_tx_min_frame_pad_if.master  m_axis,
  output logic                     frame_padded
);

  localparam int             CNT_W   = $clog2(MIN_FRAME_BYTES + 1);
  localparam logic [CNT_W:0] MIN_EXT = (CNT_W+1)'(MIN_FRAME_BYTES);
  localparam logic [CNT_W:0] KW_EXT  = (CNT_W+1)'(KEEP_WIDTH);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME_BYTES);

  pad_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_en_q, rdy_en_d;

  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_sat;
  logic [CNT_W:0]    sum_kw;
  logic [CNT_W:0]    total;

  logic                  ld, ld_last, ld_pad;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [KEEP_WIDTH-1:0] ld_keep;

  logic                  m_valid, m_last, m_pad;
  logic [DATA_WIDTH-1:0] m_data;
  logic [KEEP_WIDTH-1:0] m_keep;

  logic out_free, s_rdy, s_fire, m_fire;

  // rdy_en holds input ready low through the reset cycle and releases it
  // on the first cycle after reset deasserts.
  assign out_free = !m_valid || m_axis.trdy;
  assign s_rdy    = rdy_en_q && (state_q == PASS) && out_free;
  assign s_fire   = s_axis.tvalid && s_rdy;
  assign m_fire   = m_valid && m_axis.trdy;

  always_comb begin
    state_d  = state_q;
    rdy_en_d = 1'b1;
    // The count belongs to the frame currently in the output stage; once
    // its tlast leaves, a beat accepted in the same cycle starts from zero.
    cnt_base = (m_fire && m_last) ? '0 : cnt_q;
    sum_kw   = {1'b0, cnt_base} + KW_EXT;
    total    = {1'b0, cnt_base} + (CNT_W+1)'(axis_keep_popcount(s_axis.tkeep));
    cnt_sat  = (sum_kw >= MIN_EXT) ? MIN_CNT : sum_kw[CNT_W-1:0];
    cnt_d    = cnt_base;
    ld       = 1'b0;
    ld_data  = s_axis.tdata;
    ld_keep  = s_axis.tkeep;
    ld_last  = 1'b0;
    ld_pad   = 1'b0;
    case (state_q)
      PASS: begin
        if (s_fire) begin
          ld    = 1'b1;
          cnt_d = cnt_sat;
          if (s_axis.tlast) begin
            if (total >= MIN_EXT) begin
              ld_last = 1'b1;
            end else begin
              // Short frame: widen the last beat to a full word of zeros
              // beyond the user bytes.
              ld_data = s_axis.tdata & axis_keep_to_byte_mask(s_axis.tkeep);
              ld_keep = '1;
              ld_pad  = 1'b1;
              if (sum_kw == MIN_EXT) begin
                ld_last = 1'b1;
              end else begin
                state_d = PAD;
              end
            end
          end
        end
      end
      PAD: begin
        if (out_free) begin
          ld      = 1'b1;
          ld_data = '0;
          ld_keep = '1;
          ld_pad  = 1'b1;
          cnt_d   = cnt_sat;
          // Leave PAD as the final filler beat is loaded so the next frame
          // can be taken in the cycle that beat is accepted downstream.
          if (sum_kw >= MIN_EXT) begin
            ld_last = 1'b1;
            state_d = PASS;
          end
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PASS;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  axis_tx_min_frame_pad_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (ld),
    .load_data (ld_data),
    .load_keep (ld_keep),
    .load_last (ld_last),
    .load_pad  (ld_pad),
    .out_rdy   (m_axis.trdy),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_keep  (m_keep),
    .out_last  (m_last),
    .out_pad   (m_pad)
  );

  assign s_axis.trdy   = s_rdy;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_data;
  assign m_axis.tkeep  = m_keep;
  assign m_axis.tlast  = m_last;
  assign frame_padded  = m_fire && m_last && m_pad;

  logic [KEEP_WIDTH-1:0] keep_inc;
  assign keep_inc = s_axis.tkeep + KEEP_WIDTH'(1);

  a_mid_keep_full: assert property (@(posedge clk) disable iff (reset)
    (s_fire && !s_axis.tlast) |-> (&s_axis.tkeep));

  a_last_keep_contig: assert property (@(posedge clk) disable iff (reset)
    (s_fire && s_axis.tlast) |-> ((s_axis.tkeep != '0) && ((s_axis.tkeep & keep_inc) == '0)));

endmodule

// File: tb/tb_axis_tx_min_frame_pad.sv
module tb_axis_tx_min_frame_pad;

  typedef struct {
    int          n;
    logic [3:0]  lkeep;
    logic [31:0] base;
    int          mode;
    int          exp_beats;
    int          exp_pad;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    int          cyc;
  } beat_t;

  logic clk;
  logic reset;
  logic frame_padded;

  axis_tx_min_frame_pad_if s_if ();
  axis_tx_min_frame_pad_if m_if ();

  axis_tx_min_frame_pad dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis       (s_if.slave),
    .m_axis       (m_if.master),
    .frame_padded (frame_padded)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ph = 0;
  int trdy_mode = 0;
  int cur_in_n = 0;
  int out_idx = 0;
  int last_cnt = 0;
  int pad_cnt = 0;
  beat_t got[$];
  beat_t exp_q[$];
  vec_t vecs[9];

  bit    stall_q = 0;
  beat_t hold;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_if.trdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      if (trdy_mode == 0) m_if.trdy = 1'b1;
      else m_if.trdy = ((ph % 4) == 0) || ((ph % 4) == 3);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 0;
      out_idx = 0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", m_if.tvalid, 1'b1);
        chk("hold_beat", {m_if.tdata, m_if.tkeep, m_if.tlast}, {hold.data, hold.keep, hold.last});
      end
      if (m_if.tvalid && !m_if.trdy) begin
        stall_q   = 1;
        hold.data = m_if.tdata;
        hold.keep = m_if.tkeep;
        hold.last = m_if.tlast;
      end else begin
        stall_q = 0;
      end
      if (m_if.tvalid && cur_in_n > 0 && !m_if.tlast && out_idx >= cur_in_n - 1)
        chk("s_trdy_in_pad", s_if.trdy, 1'b0);
      if (frame_padded) pad_cnt++;
      if (m_if.tvalid && m_if.trdy) begin
        got.push_back('{m_if.tdata, m_if.tkeep, m_if.tlast, cyc});
        out_idx++;
        if (m_if.tlast) begin
          last_cnt++;
          out_idx = 0;
        end
      end
    end
  end

  function automatic logic [31:0] beat_data(input logic [31:0] base, input int i);
    return base + 32'(i) * 32'h01010101;
  endfunction

  // Reference: user beats, last beat widened and zero-filled when short,
  // then zero beats up to 60 bytes.
  task automatic build_exp(input int n, input logic [3:0] lk, input logic [31:0] base);
    int bytes;
    int out_n;
    beat_t b;
    bytes = (n - 1) * 4;
    for (int k = 0; k < 4; k++) if (lk[k]) bytes++;
    out_n = (bytes >= 60) ? n : 15;
    for (int i = 0; i < out_n; i++) begin
      b.cyc = 0;
      if (i < n) begin
        b.data = beat_data(base, i);
        b.keep = (i == n - 1) ? lk : 4'hF;
        if (i == n - 1 && bytes < 60) begin
          for (int k = 0; k < 4; k++) if (!lk[k]) b.data[k*8 +: 8] = 8'h00;
          b.keep = 4'hF;
        end
      end else begin
        b.data = 32'h0;
        b.keep = 4'hF;
      end
      b.last = (i == out_n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, output int acc);
    int t;
    t = 0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    while (!s_if.trdy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      total++;
      bad++;
      $display("FAIL s_accept_timeout: s_trdy stuck at %0b", s_if.trdy);
    end
    acc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [3:0] lk, input logic [31:0] base, output int first_acc);
    int acc;
    first_acc = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(beat_data(base, i), (i == n - 1) ? lk : 4'hF, (i == n - 1), acc);
      if (i == 0) first_acc = acc;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int k);
    int t;
    t = 0;
    while (last_cnt < k && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk({tag, "_frames_done"}, last_cnt, k);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cmp_beats(input string tag);
    int m;
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int j = 0; j < m; j++)
      chk($sformatf("%s_beat%0d", tag, j), {got[j].data, got[j].keep, got[j].last},
          {exp_q[j].data, exp_q[j].keep, exp_q[j].last});
  endtask

  task automatic start_frame_set();
    @(posedge clk);
    #1;
    got.delete();
    exp_q.delete();
    last_cnt = 0;
    pad_cnt  = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int acc;
    string tag;
    tag = $sformatf("v%0d", idx);
    trdy_mode = v.mode;
    start_frame_set();
    cur_in_n = v.n;
    build_exp(v.n, v.lkeep, v.base);
    send_frame(v.n, v.lkeep, v.base, acc);
    wait_frames(tag, 1);
    chk({tag, "_nbeats"}, got.size(), v.exp_beats);
    chk({tag, "_padded_pulses"}, pad_cnt, v.exp_pad);
    cmp_beats(tag);
  endtask

  initial begin
    int acc1, acc2, t;
    //           n   lkeep  base          mode beats pad
    vecs[0] = '{ 1, 4'h1, 32'hDDCCBBAA, 0, 15, 1};
    vecs[1] = '{15, 4'h3, 32'h10203040, 0, 15, 1};
    vecs[2] = '{15, 4'hF, 32'h55667788, 0, 15, 0};
    vecs[3] = '{16, 4'hF, 32'h0A0B0C0D, 0, 16, 0};
    vecs[4] = '{ 1, 4'h1, 32'hDDCCBBAA, 1, 15, 1};
    vecs[5] = '{ 3, 4'h7, 32'hC0FFEE11, 0, 15, 1};
    vecs[6] = '{15, 4'h1, 32'h89ABCDEF, 1, 15, 1};
    vecs[7] = '{17, 4'h3, 32'h13579BDF, 1, 17, 0};
    vecs[8] = '{14, 4'hF, 32'h2468ACE0, 0, 15, 1};

    reset       = 1'b1;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_if.tvalid, 1'b0);
    chk("rst_m_data", m_if.tdata, 32'h0);
    chk("rst_m_keep", m_if.tkeep, 4'h0);
    chk("rst_m_last", m_if.tlast, 1'b0);
    chk("rst_s_trdy", s_if.trdy, 1'b0);
    chk("rst_frame_padded", frame_padded, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rel_s_trdy_still_low", s_if.trdy, 1'b0);
    @(negedge clk);
    chk("rel_s_trdy_high", s_if.trdy, 1'b1);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // First vector re-run for its hand-computed first beat.
    trdy_mode = 0;
    start_frame_set();
    cur_in_n = 1;
    send_frame(1, 4'h1, 32'hDDCCBBAA, acc1);
    wait_frames("tp1", 1);
    if (got.size() > 0) chk("tp1_first_beat", {got[0].data, got[0].keep}, {32'h000000AA, 4'hF});
    else chk("tp1_first_beat_missing", got.size(), 15);

    // 64-byte frame then 4-byte frame, back to back.
    trdy_mode = 0;
    start_frame_set();
    cur_in_n = 0;
    build_exp(16, 4'hF, 32'h31415926);
    build_exp(1, 4'hF, 32'hFEEDF00D);
    send_frame(16, 4'hF, 32'h31415926, acc1);
    send_frame(1, 4'hF, 32'hFEEDF00D, acc2);
    wait_frames("b2b", 2);
    chk("b2b_nbeats", got.size(), 31);
    chk("b2b_padded_pulses", pad_cnt, 1);
    cmp_beats("b2b");
    if (got.size() >= 17) begin
      chk("b2b_accept_with_tlast", acc2, got[15].cyc);
      chk("b2b_no_idle", got[16].cyc, got[15].cyc + 1);
    end else begin
      chk("b2b_short", got.size(), 31);
    end

    // Reset in the middle of padding.
    trdy_mode = 0;
    start_frame_set();
    cur_in_n = 0;
    send_frame(1, 4'h1, 32'hABCDEF01, acc1);
    t = 0;
    while (got.size() < 6 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("midpad_reached", got.size() >= 6, 1'b1);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midpad_rst_m_valid", m_if.tvalid, 1'b0);
    chk("midpad_rst_padded", frame_padded, 1'b0);
    chk("midpad_rst_s_trdy", s_if.trdy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midpad_no_tlast", last_cnt, 0);
    chk("midpad_no_pulse", pad_cnt, 0);
    got.delete();
    exp_q.delete();
    cur_in_n = 1;
    build_exp(1, 4'hF, 32'h0BADCAFE);
    send_frame(1, 4'hF, 32'h0BADCAFE, acc1);
    wait_frames("after_rst", 1);
    chk("after_rst_nbeats", got.size(), 15);
    chk("after_rst_padded_pulses", pad_cnt, 1);
    cmp_beats("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_tx_min_frame_pad.md
Name: axis_tx_min_frame_pad

Overview:
- Sits directly downstream of the AXI-Stream TX source and directly upstream of the MAC TX framer.
- Consumes user frames on a 32-bit AXI-Stream slave. Any frame shorter than MIN_FRAME_BYTES (pre-FCS) is zero-padded up to that length; longer frames pass through unchanged.
- Registered output stage, with a per-frame pad indication for statistics.

Parameters:
- DATA_WIDTH, 32, stream data width in bits. Must be a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
- MIN_FRAME_BYTES, 60, minimum frame length excluding FCS. Must be a multiple of KEEP_WIDTH.

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous reset, active-high
- s_axis_tdata  in  DATA_WIDTH  input beat data; byte 0 in bits [7:0]
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  last beat of frame
- s_axis_trdy  out  1  block accepts input beat
- m_axis_tdata  out  DATA_WIDTH  output beat data
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables
- m_axis_tvalid  out  1  output beat valid
- m_axis_tlast  out  1  last beat of output frame
- m_axis_trdy  in  1  downstream ready
- frame_padded  out  1  one-cycle pulse when a frame's final (padded) beat is accepted downstream

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset (sampled at posedge clk while reset=1):
  - All outputs go to 0 (s_axis_trdy=0, m_axis_* = 0, frame_padded=0).
  - State goes to PASS; byte counter is cleared.
  - A frame in progress is abandoned; no tlast is emitted for it.
  - s_axis_trdy goes to 1 the first cycle after reset deasserts.
- Input rules:
  - Non-last beats must have tkeep all-ones.
  - The last beat's tkeep must be contiguous from bit 0 and non-zero.
  - Violations are undefined behaviour; add a sim-only assertion for them.
- Handshakes:
  - Transfer occurs when valid and ready are both high at posedge.
  - m_axis_tvalid, once asserted, holds with data, tkeep and tlast stable until m_axis_trdy=1.
  - s_axis_trdy = (state==PASS) and (!m_axis_tvalid or m_axis_trdy). This is combinational from m_axis_trdy, so no skid buffer is needed.
- Latency: an accepted input beat appears on m_axis the next cycle. With continuous ready, throughput is 1 beat/cycle in PASS.
- Byte counter:
  - Width is clog2(MIN_FRAME_BYTES+1) bits and saturates at MIN_FRAME_BYTES.
  - Adds KEEP_WIDTH per accepted non-last beat or per emitted pad beat.
  - Clears on acceptance of the final output beat of a frame.
- State PASS:
  - Non-last beat: forwarded unchanged; counter advances.
  - Last beat with total = count + popcount(tkeep) >= MIN_FRAME_BYTES: forwarded unchanged with tlast=1; no pad.
  - Last beat with total < MIN and count+KEEP_WIDTH == MIN: emitted with tkeep all-ones, disabled bytes forced to 0x00, tlast=1; frame_padded fires on acceptance.
  - Last beat with count+KEEP_WIDTH < MIN: emitted with tkeep all-ones, disabled bytes zeroed, tlast=0; go to PAD.
- State PAD (s_axis_trdy=0):
  - Each accepted output beat is tdata=0, tkeep all-ones; counter += KEEP_WIDTH.
  - The beat that brings the counter to MIN carries tlast=1. On its acceptance, pulse frame_padded, clear the counter and return to PASS.
- Boundaries:
  - Single-beat frame with tkeep=0x1 expands to 15 beats (60 bytes).
  - A frame of exactly MIN bytes is never flagged.
  - A frame longer than MIN has the counter saturate with no wrap; the frame passes through.
  - Back-to-back frames: the next frame's first beat can be accepted in the same cycle the previous tlast is accepted downstream.
  - m_axis_trdy low for N cycles stalls PAD emission with no lost or duplicated pad beats.

Decomposition:
- mac_pkg additions:
  - MIN_FRAME_BYTES constant (60).
  - axis_keep_popcount function.
  - axis_keep_to_byte_mask function (expands tkeep to a bit mask).
  - pad_state_t enum {PASS, PAD}.
- Optional sub-module axis_out_reg: the registered output stage holding data, tkeep and tlast stable under backpressure.

Test Plan:
- 1-beat frame, tdata=0xDDCCBBAA, tkeep=0x1, tlast=1, m_axis_trdy=1 -> beat 1 tdata=0x000000AA tkeep=0xF; then 14 zero beats; 15th has tlast=1; frame_padded pulses once.
- 14 full beats plus last beat tkeep=0x3 (58 bytes) -> 15 output beats; last beat tkeep=0xF, bytes 2-3 zero, tlast=1; no PAD beats; frame_padded=1.
- 15 full beats (exactly 60 bytes) -> passed unchanged, tlast on beat 15, frame_padded=0.
- 64-byte frame (16 beats), then immediately a 4-byte frame -> first passes untouched; second padded to 60 bytes; no idle cycle between frames with m_axis_trdy=1.
- 1-beat frame with m_axis_trdy toggling 1,0,0,1 repeatedly -> exactly 15 output beats, data stable during stalls, s_axis_trdy=0 throughout PAD.
- Reset asserted mid-PAD after 5 pad beats -> next cycle m_axis_tvalid=0, frame_padded=0; after release, a fresh 4-byte frame yields exactly 15 beats.
